// File: rtl/tick_sequencer.sv
// Countdown timer controller: a TICK_DIV prescaler generates tick enables that count a loaded value down to zero.
// Optional periodic mode via TICK_SEQ_AUTO_RELOAD_EN (reload on the final tick instead of passing through DONE).
module tick_sequencer #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clock_in,
  input  logic             clear,
  input  logic             start,
  input  logic             pause,
  input  logic             resume,
  input  logic             abort,
  input  logic [CNT_W-1:0] load_value,
  output logic [CNT_W-1:0] remaining,
  output logic             tick,
  output logic             done,
  output logic             busy,
  output logic             paused,
  output logic [1:0]       state
);

  localparam int unsigned PRE_W = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             cur_q, nxt;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [CNT_W-1:0]   rem_d;
  logic               tick_d, done_d;
  logic               advance;
`ifdef TICK_SEQ_AUTO_RELOAD_EN
  logic [CNT_W-1:0]   latch_q, latch_d;
`endif

  // Next-state, prescaler and countdown; the resume edge counts as a prescaler step
  always_comb begin
    nxt     = cur_q;
    pre_d   = pre_q;
    rem_d   = remaining;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    advance = 1'b0;
`ifdef TICK_SEQ_AUTO_RELOAD_EN
    latch_d = latch_q;
`endif

    if (abort) begin
      nxt   = S_IDLE;
      pre_d = '0;
      rem_d = '0;
    end else begin
      unique case (cur_q)
        S_IDLE, S_RUN: begin
          if (cur_q == S_RUN && pause) begin
            nxt = S_PAUSE;
          end else if (start) begin
            pre_d = '0;
            if (load_value == '0) begin
              nxt    = S_DONE;
              done_d = 1'b1;
              rem_d  = '0;
            end else begin
              nxt   = S_RUN;
              rem_d = load_value;
`ifdef TICK_SEQ_AUTO_RELOAD_EN
              latch_d = load_value;
`endif
            end
          end else if (cur_q == S_RUN) begin
            advance = 1'b1;
          end
        end
        S_PAUSE: begin
          if (!pause && resume) begin
            nxt     = S_RUN;
            advance = 1'b1;
          end
        end
        S_DONE: nxt = S_IDLE;
        default: nxt = S_IDLE;
      endcase
    end

    if (advance) begin
      if (pre_q == PRE_W'(TICK_DIV - 1)) begin
        pre_d = '0;
        if (remaining != '0) begin
          tick_d = 1'b1;
          rem_d  = remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            done_d = 1'b1;
`ifdef TICK_SEQ_AUTO_RELOAD_EN
            rem_d = latch_q;
`else
            nxt   = S_DONE;
`endif
          end
        end
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clock_in or posedge clear) begin
    if (clear) begin
      cur_q     <= S_IDLE;
      pre_q     <= '0;
      remaining <= '0;
      tick      <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      paused    <= 1'b0;
      state     <= 2'd0;
`ifdef TICK_SEQ_AUTO_RELOAD_EN
      latch_q   <= '0;
`endif
    end else begin
      cur_q     <= nxt;
      pre_q     <= pre_d;
      remaining <= rem_d;
      tick      <= tick_d;
      done      <= done_d;
      busy      <= (nxt == S_RUN) || (nxt == S_PAUSE);
      paused    <= (nxt == S_PAUSE);
      state     <= nxt;
`ifdef TICK_SEQ_AUTO_RELOAD_EN
      latch_q   <= latch_d;
`endif
    end
  end

endmodule

// File: tb/tb_tick_sequencer.sv
// Self-checking bench for tick_sequencer (TICK_DIV=4, CNT_W=8): per-cycle model compare plus directed literal checks.
module tb_tick_sequencer;

  localparam int unsigned DIV = 4;
  localparam int unsigned W   = 8;

  logic         clock_in = 1'b0;
  logic         clear = 1'b0, start = 1'b0, pause = 1'b0, resume = 1'b0, abort = 1'b0;
  logic [W-1:0] load_value = '0;
  logic [W-1:0] remaining;
  logic         tick, done, busy, paused;
  logic [1:0]   state;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  int m_mode, m_rem, m_pre;
  bit m_tick, m_done;
`ifdef TICK_SEQ_AUTO_RELOAD_EN
  int m_latch;
`endif

  logic [31:0] tmask, dmask, pmask, bmask;
  int          rem_at [0:31];
  int          st_at  [0:31];

  tick_sequencer #(.TICK_DIV(DIV), .CNT_W(W)) dut (
    .clock_in  (clock_in),
    .clear     (clear),
    .start     (start),
    .pause     (pause),
    .resume    (resume),
    .abort     (abort),
    .load_value(load_value),
    .remaining (remaining),
    .tick      (tick),
    .done      (done),
    .busy      (busy),
    .paused    (paused),
    .state     (state)
  );

  always #5 clock_in = ~clock_in;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Model: a countdown that loses one step per tick, where a tick is every DIV-th counted edge
  task m_load(input int lv);
    m_pre = 0;
    if (lv == 0) begin
      m_mode = 3;
      m_done = 1'b1;
      m_rem  = 0;
    end else begin
      m_mode = 1;
      m_rem  = lv;
`ifdef TICK_SEQ_AUTO_RELOAD_EN
      m_latch = lv;
`endif
    end
  endtask

  task m_count();
    m_pre++;
    if (m_pre == DIV) begin
      m_pre = 0;
      if (m_rem > 0) begin
        m_tick = 1'b1;
        m_rem--;
        if (m_rem == 0) begin
          m_done = 1'b1;
`ifdef TICK_SEQ_AUTO_RELOAD_EN
          m_rem = m_latch;
`else
          m_mode = 3;
`endif
        end
      end
    end
  endtask

  always @(posedge clock_in or posedge clear) begin
    if (clear) begin
      m_mode = 0; m_rem = 0; m_pre = 0; m_tick = 1'b0; m_done = 1'b0;
`ifdef TICK_SEQ_AUTO_RELOAD_EN
      m_latch = 0;
`endif
    end else begin
      m_tick = 1'b0;
      m_done = 1'b0;
      if (abort) begin
        m_mode = 0; m_rem = 0; m_pre = 0;
      end else begin
        case (m_mode)
          0: if (start) m_load(int'(load_value));
          1: begin
            if (pause) m_mode = 2;
            else if (start) m_load(int'(load_value));
            else m_count();
          end
          2: if (!pause && resume) begin m_mode = 1; m_count(); end
          default: m_mode = 0;
        endcase
      end
    end
  end

  always @(negedge clock_in) begin
    if (cmp_en)
      chk("cycle_outputs",
          32'({state, remaining, tick, done, busy, paused}),
          32'({2'(m_mode), W'(m_rem), m_tick, m_done, (m_mode == 1 || m_mode == 2), (m_mode == 2)}));
  end

  task automatic drive(input logic s, input logic p, input logic r, input logic a, input int lv);
    start = s; pause = p; resume = r; abort = a; load_value = W'(lv);
  endtask

  task automatic sample(input int k);
    tmask[k] = tick; dmask[k] = done; pmask[k] = paused; bmask[k] = busy;
    rem_at[k] = int'(remaining); st_at[k] = int'(state);
  endtask

  task automatic arm(input int lv);
    tmask = '0; dmask = '0; pmask = '0; bmask = '0;
    @(negedge clock_in); #1 drive(1'b1, 1'b0, 1'b0, 1'b0, lv);
  endtask

  initial begin
    #1 clear = 1'b1;
    repeat (2) @(negedge clock_in);
    #1 clear = 1'b0;
    cmp_en = 1'b1;

    // Reset asserted between edges clears a running countdown immediately
    arm(7);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock_in); sample(k);
      #1 drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
    end
    chk("pre_clear_busy", 32'(busy), 32'd1);
    #1 clear = 1'b1;
    #1;
    chk("clr_remaining", 32'(remaining), 32'd0);
    chk("clr_state", 32'(state), 32'd0);
    chk("clr_flags", 32'({tick, done, busy, paused}), 32'd0);
    @(negedge clock_in); #1 clear = 1'b0;
    dmask = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock_in); sample(k);
    end
    chk("clr_no_done", dmask, 32'd0);

    // Basic countdown of 3
    arm(3);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock_in); sample(k);
      #1 drive(1'b0, 1'b0, 1'b0, (k == 15), 0);
    end
    chk("basic_ticks", tmask, 32'h0000_2220);
    chk("basic_done", dmask, 32'h0000_2000);
    chk("basic_rem5", 32'(rem_at[5]), 32'd2);
    chk("basic_rem9", 32'(rem_at[9]), 32'd1);
    chk("basic_rem13", 32'(rem_at[13]), 32'd0);
`ifndef TICK_SEQ_AUTO_RELOAD_EN
    chk("basic_busy14", 32'(bmask[14]), 32'd0);
`endif

    // Ten-cycle pause starting two cycles into the first interval
    arm(3);
    for (int k = 1; k <= 25; k++) begin
      @(negedge clock_in); sample(k);
      if (k >= 3 && k <= 12) chk("pause_frozen", 32'(remaining), 32'd3);
      #1 drive(1'b0, (k >= 2 && k <= 11), (k == 12), (k == 25), 0);
    end
    chk("pause_ticks", tmask, 32'h0088_8000);
    chk("pause_flag", pmask, 32'h0000_1FF8);
    chk("pause_done", dmask, 32'h0080_0000);

    // Pause on the wrap edge defers the tick by one cycle
    arm(3);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock_in); sample(k);
      #1 drive(1'b0, (k == 4), (k == 5), (k == 7), 0);
    end
    chk("wrap_ticks", tmask, 32'h0000_0040);
    chk("wrap_state5", 32'(st_at[5]), 32'd2);
    chk("wrap_rem6", 32'(rem_at[6]), 32'd2);

    // Abort after the first tick
    arm(3);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock_in); sample(k);
      #1 drive(1'b0, 1'b0, 1'b0, (k == 5), 0);
    end
    chk("abort_tick5", 32'(tmask[5]), 32'd1);
    chk("abort_state6", 32'(st_at[6]), 32'd0);
    chk("abort_rem6", 32'(rem_at[6]), 32'd0);
    chk("abort_no_done", dmask, 32'd0);

    // Restart while running reloads and realigns the prescaler
    arm(3);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock_in); sample(k);
      #1 drive((k == 3), 1'b0, 1'b0, (k == 9), (k == 3) ? 5 : 0);
    end
    chk("restart_rem4", 32'(rem_at[4]), 32'd5);
    chk("restart_state4", 32'(st_at[4]), 32'd1);
    chk("restart_ticks", tmask, 32'h0000_0100);
    chk("restart_rem8", 32'(rem_at[8]), 32'd4);

    // Zero load goes straight through DONE
    arm(0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock_in); sample(k);
      #1 drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
    end
    chk("zero_state1", 32'(st_at[1]), 32'd3);
    chk("zero_done1", 32'(dmask[1]), 32'd1);
    chk("zero_state2", 32'(st_at[2]), 32'd0);
    chk("zero_no_tick", tmask, 32'd0);

`ifdef TICK_SEQ_AUTO_RELOAD_EN
    // Periodic operation with load 2
    arm(2);
    for (int k = 1; k <= 26; k++) begin
      @(negedge clock_in); sample(k);
      #1 drive(1'b0, 1'b0, 1'b0, (k == 26), 0);
    end
    chk("auto_done", dmask, 32'h0202_0200);
    chk("auto_busy", bmask & 32'h07FF_FFFE, 32'h07FF_FFFE);
    chk("auto_rem9", 32'(rem_at[9]), 32'd2);
    chk("auto_rem17", 32'(rem_at[17]), 32'd2);
    chk("auto_rem25", 32'(rem_at[25]), 32'd2);
`endif

    repeat (3) @(negedge clock_in);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
